// File: rtl/gun_pos_integrator.sv
// Light-gun crosshair generator: integrates digital directions or follows an analog
// stick into saturating H/V coordinates, updating once per rising edge of tick.
module gun_pos_integrator #(
  parameter int POS_W      = 6,
  parameter int DIV_MAX    = 4,
  parameter int ACCEL_HOLD = 8,
  parameter int DEADZONE   = 4
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             tick,
  input  logic             mode_analog,
  input  logic             accel_en,
  input  logic             recenter,
  input  logic             m_left,
  input  logic             m_right,
  input  logic             m_up,
  input  logic             m_down,
  input  logic [7:0]       ana_x,
  input  logic [7:0]       ana_y,
  output logic [POS_W-1:0] gun_h,
  output logic [POS_W-1:0] gun_v,
  output logic             moving
);

  localparam int DW = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int HW = $clog2(2 * ACCEL_HOLD + 1);
  // Sum width must hold max position plus the largest step (4) without wrapping.
  localparam int AW = (POS_W + 2 < 4) ? 4 : POS_W + 2;

  localparam logic [POS_W-1:0] CENTER   = POS_W'(2 ** (POS_W - 1));
  localparam logic [AW-1:0]    MAX_POS  = AW'(2 ** POS_W - 1);
  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV_MAX - 1);
  localparam logic [HW-1:0]    HOLD_1   = HW'(ACCEL_HOLD);
  localparam logic [HW-1:0]    HOLD_SAT = HW'(2 * ACCEL_HOLD);

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic [DW-1:0]    div;
    logic [HW-1:0]    hold;
  } axis_t;

  localparam axis_t AXIS_RST = '{pos: CENTER, div: '0, hold: '0};

  axis_t h_q, v_q, h_d, v_d;
  logic  tick_d;
  logic  upd;
  logic  moving_d;

  function automatic axis_t dig_axis(axis_t cur, logic plus, logic minus, logic accel);
    axis_t         nx;
    logic [2:0]    mag;
    logic [AW-1:0] base;
    logic [AW-1:0] sum;
    nx = cur;
    if (plus ^ minus) begin
      if (cur.div == '0) begin
        if (!accel || cur.hold < HOLD_1) mag = 3'd1;
        else if (cur.hold < HOLD_SAT)    mag = 3'd2;
        else                             mag = 3'd4;
        base = AW'(cur.pos);
        if (plus) begin
          sum    = base + AW'(mag);
          nx.pos = (sum > MAX_POS) ? MAX_POS[POS_W-1:0] : sum[POS_W-1:0];
        end else begin
          sum    = base - AW'(mag);
          nx.pos = (AW'(mag) > base) ? '0 : sum[POS_W-1:0];
        end
        nx.hold = (cur.hold == HOLD_SAT) ? cur.hold : cur.hold + 1'b1;
      end
      nx.div = (cur.div == DIV_LAST) ? '0 : cur.div + 1'b1;
    end else begin
      nx.div  = '0;
      nx.hold = '0;
    end
    return nx;
  endfunction

  // Offset-binary top bits; magnitude is taken in 9 bits so -128 reads as 128.
  function automatic axis_t ana_axis(logic [7:0] a);
    axis_t      nx;
    logic [8:0] absv;
    logic [7:0] ob;
    absv = a[7] ? (9'd0 - {a[7], a}) : {1'b0, a};
    ob   = {~a[7], a[6:0]};
    nx   = AXIS_RST;
    if (absv >= 9'(DEADZONE)) nx.pos = ob[7 -: POS_W];
    return nx;
  endfunction

  assign upd = tick & ~tick_d;

  always_comb begin
    h_d      = h_q;
    v_d      = v_q;
    moving_d = moving;
    if (upd) begin
      if (recenter) begin
        h_d = AXIS_RST;
        v_d = AXIS_RST;
      end else if (mode_analog) begin
        h_d = ana_axis(ana_x);
        v_d = ana_axis(ana_y);
      end else begin
        h_d = dig_axis(h_q, m_right, m_left, accel_en);
        v_d = dig_axis(v_q, m_down, m_up, accel_en);
      end
      moving_d = (h_d.pos != h_q.pos) || (v_d.pos != v_q.pos);
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tick_d <= 1'b0;
      h_q    <= AXIS_RST;
      v_q    <= AXIS_RST;
      moving <= 1'b0;
    end else begin
      tick_d <= tick;
      h_q    <= h_d;
      v_q    <= v_d;
      moving <= moving_d;
    end
  end

  assign gun_h = h_q.pos;
  assign gun_v = v_q.pos;

endmodule

// File: tb/tb_gun_pos_integrator.sv
// Directed bench for gun_pos_integrator at POS_W=6, DIV_MAX=4, ACCEL_HOLD=8, DEADZONE=4.
module tb_gun_pos_integrator;

  logic       clk_sys = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       mode_analog = 1'b0;
  logic       accel_en = 1'b0;
  logic       recenter = 1'b0;
  logic       m_left = 1'b0;
  logic       m_right = 1'b0;
  logic       m_up = 1'b0;
  logic       m_down = 1'b0;
  logic [7:0] ana_x = 8'h00;
  logic [7:0] ana_y = 8'h00;
  logic [5:0] gun_h;
  logic [5:0] gun_v;
  logic       moving;

  int checks = 0;
  int errors = 0;

  gun_pos_integrator #(
    .POS_W(6), .DIV_MAX(4), .ACCEL_HOLD(8), .DEADZONE(4)
  ) dut (
    .clk_sys(clk_sys), .reset(reset), .tick(tick), .mode_analog(mode_analog),
    .accel_en(accel_en), .recenter(recenter), .m_left(m_left), .m_right(m_right),
    .m_up(m_up), .m_down(m_down), .ana_x(ana_x), .ana_y(ana_y),
    .gun_h(gun_h), .gun_v(gun_v), .moving(moving)
  );

  // clock / reset
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One update: tick high for one clock, then low for one, sample 1 ns after an edge.
  task automatic step_tick();
    @(posedge clk_sys); #1 tick = 1'b1;
    @(posedge clk_sys); #1 tick = 1'b0;
    @(posedge clk_sys); #1;
  endtask

  logic [5:0] exp_left [20] = '{31, 30, 29, 28, 27, 26, 25, 24,
                                22, 20, 18, 16, 14, 12, 10, 8,
                                4, 0, 0, 0};

  initial begin
    repeat (3) @(posedge clk_sys);
    #1 reset = 1'b0;
    check("rst_h", gun_h, 32);
    check("rst_v", gun_v, 32);
    check("rst_moving", moving, 0);

    // idle ticks
    repeat (10) step_tick();
    check("idle_h", gun_h, 32);
    check("idle_v", gun_v, 32);
    check("idle_moving", moving, 0);

    // digital right, no acceleration, rate division
    m_right = 1'b1;
    step_tick();
    check("right_t1_h", gun_h, 33);
    check("right_t1_moving", moving, 1);
    step_tick();
    check("right_t2_h", gun_h, 33);
    check("right_t2_moving", moving, 0);
    step_tick();
    step_tick();
    check("right_t4_h", gun_h, 33);
    step_tick();
    check("right_t5_h", gun_h, 34);
    check("right_t5_moving", moving, 1);
    m_right = 1'b0;
    repeat (3) step_tick();
    check("release_h", gun_h, 34);
    check("release_moving", moving, 0);

    // recenter, then accelerated left into the lower clamp
    recenter = 1'b1;
    step_tick();
    check("recenter1_h", gun_h, 32);
    check("recenter1_moving", moving, 1);
    recenter = 1'b0;
    accel_en = 1'b1;
    m_left = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step_tick();
      check($sformatf("left_move%0d_h", k + 1), gun_h, exp_left[k]);
      check($sformatf("left_move%0d_moving", k + 1), moving, (k < 18) ? 1 : 0);
      repeat (3) step_tick();
    end
    check("left_v", gun_v, 32);
    m_left = 1'b0;

    // analog positions v at 38, then accelerated down into the upper clamp
    mode_analog = 1'b1;
    ana_x = 8'h00;
    ana_y = 8'h18;
    step_tick();
    check("ana_pre_h", gun_h, 32);
    check("ana_pre_v", gun_v, 38);
    mode_analog = 1'b0;
    m_down = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      step_tick();
      if (k == 8)  check("down_move8_v", gun_v, 46);
      if (k == 16) check("down_move16_v", gun_v, 62);
      if (k == 17) check("down_move17_v", gun_v, 63);
      repeat (3) step_tick();
    end
    m_down = 1'b0;

    // opposing directions cancel and clear the divider
    m_left = 1'b1;
    m_right = 1'b1;
    repeat (5) step_tick();
    check("both_h", gun_h, 32);
    check("both_moving", moving, 0);
    m_left = 1'b0;
    step_tick();
    check("after_both_h", gun_h, 33);
    check("after_both_moving", moving, 1);
    m_right = 1'b0;

    // analog absolute mode with one-clock latency
    mode_analog = 1'b1;
    ana_x = 8'h7F;
    @(posedge clk_sys); #1 tick = 1'b1;
    #1 check("ana_lat_before_h", gun_h, 33);
    @(posedge clk_sys); #1 check("ana_lat_after_h", gun_h, 63);
    tick = 1'b0;
    @(posedge clk_sys); #1;
    check("ana_127_v", gun_v, 38);
    ana_x = 8'h80;
    step_tick();
    check("ana_m128_h", gun_h, 0);
    ana_x = 8'h03;
    step_tick();
    check("ana_dead_h", gun_h, 32);
    ana_y = 8'hFC;
    step_tick();
    check("ana_m4_v", gun_v, 31);
    check("ana_m4_moving", moving, 1);
    ana_x = 8'h20;
    step_tick();
    check("ana_40_h", gun_h, 40);

    // recenter wins over direction input
    recenter = 1'b1;
    m_right = 1'b1;
    step_tick();
    check("recenter2_h", gun_h, 32);
    check("recenter2_v", gun_v, 32);
    check("recenter2_moving", moving, 1);
    recenter = 1'b0;
    mode_analog = 1'b0;
    step_tick();
    check("pre_areset_h", gun_h, 33);

    // async reset between clock edges
    @(posedge clk_sys); #3 reset = 1'b1;
    #1 check("areset_h", gun_h, 32);
    check("areset_v", gun_v, 32);
    check("areset_moving", moving, 0);
    @(posedge clk_sys); #1 reset = 1'b0;
    m_right = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
